// File: rtl/wen_decoder_sweep_if.sv
// Write-port bundle between the write control logic and the enable decoder.
// Carries the write request, the clear request and all registered decoder outputs.
// The decoder side uses the slave modport; the requester side uses master.
interface wen_decoder_sweep_if #(
  parameter int ADDR_W = 5
);
  localparam int NUM_OUT = 1 << ADDR_W;

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               clear_req;
  logic [NUM_OUT-1:0] wen;
  logic [ADDR_W-1:0]  wen_idx;
  logic               sweep_active;
  logic               busy;
  logic               clear_done;
  logic               wr_dropped;

  modport master (
    output wr_en, wr_addr, clear_req,
    input  wen, wen_idx, sweep_active, busy, clear_done, wr_dropped
  );

  modport slave (
    input  wr_en, wr_addr, clear_req,
    output wen, wen_idx, sweep_active, busy, clear_done, wr_dropped
  );
endinterface

// File: rtl/wen_decoder_sweep.sv
// Registered one-hot write-enable decoder with optional hard-wired zero register and clear sweep.
// Latency: 1 cycle from wr_en/clear_req to wen; a sweep emits one entry per cycle.
// No backpressure: writes arriving during a sweep (or losing to clear) are dropped and flagged.
module wen_decoder_sweep #(
  parameter int ADDR_W   = 5,
  parameter int NUM_OUT  = (1 << ADDR_W),
  parameter int ZERO_REG = 1
) (
  input logic             clk,
  input logic             reset,
  wen_decoder_sweep_if.slave bus
);

  // Top index is the zero register when ZERO_REG is set; the sweep stops just below it.
  localparam logic [ADDR_W-1:0] MASK_IDX = ADDR_W'(NUM_OUT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = (ZERO_REG != 0) ? ADDR_W'(NUM_OUT - 2)
                                                           : ADDR_W'(NUM_OUT - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              addr_masked;

  // Next sweep index and zero-register detection for the incoming write address.
  always_comb begin
    cnt_nxt     = cnt + ADDR_W'(1);
    addr_masked = (ZERO_REG != 0) && (bus.wr_addr == MASK_IDX);
  end

  // Control FSM; state always mirrors what the registered outputs currently show.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.wen          <= '0;
      bus.wen_idx      <= '0;
      bus.sweep_active <= 1'b0;
      bus.busy         <= 1'b0;
      bus.clear_done   <= 1'b0;
      bus.wr_dropped   <= 1'b0;
    end else begin
      bus.clear_done <= 1'b0;
      bus.wr_dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear_req) begin
            // Clear wins over a same-cycle write; first swept entry is index 0.
            state            <= SWEEP;
            cnt              <= '0;
            bus.wen          <= NUM_OUT'(1);
            bus.wen_idx      <= '0;
            bus.sweep_active <= 1'b1;
            bus.busy         <= 1'b1;
            bus.clear_done   <= (LAST_IDX == '0);
            bus.wr_dropped   <= bus.wr_en;
          end else if (bus.wr_en && !addr_masked) begin
            bus.wen          <= NUM_OUT'(1) << bus.wr_addr;
            bus.wen_idx      <= bus.wr_addr;
            bus.sweep_active <= 1'b0;
            bus.busy         <= 1'b0;
          end else begin
            // No write, or a silent discard to the zero register.
            bus.wen          <= '0;
            bus.wen_idx      <= '0;
            bus.sweep_active <= 1'b0;
            bus.busy         <= 1'b0;
          end
        end
        SWEEP: begin
          bus.wr_dropped <= bus.wr_en;
          if (cnt == LAST_IDX) begin
            // Terminal compare: leave one quiet IDLE cycle, never wrap the counter.
            state            <= IDLE;
            bus.wen          <= '0;
            bus.wen_idx      <= '0;
            bus.sweep_active <= 1'b0;
            bus.busy         <= 1'b0;
          end else begin
            cnt              <= cnt_nxt;
            bus.wen          <= NUM_OUT'(1) << cnt_nxt;
            bus.wen_idx      <= cnt_nxt;
            bus.sweep_active <= 1'b1;
            bus.busy         <= 1'b1;
            bus.clear_done   <= (cnt_nxt == LAST_IDX);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
